frame_streamer: RTL and testbench
=================================

Name: frame_streamer

Overview:
- Downstream stage of the image processing engine; sits after the mirror/grayscale/sharpen stage.
- When that stage pulses its final done flag, this block reads the 64x64 output image one pixel per address, in raster order.
- It emits the pixels as a valid/ready stream with frame and line markers, for display or capture logic.
- A small FIFO absorbs the one-cycle memory read latency and consumer backpressure without losing or duplicating pixels.

Parameters:
- IMG_W, 64, pixels per row.
- IMG_H, 64, rows per frame.
- ADDR_W, 6, row/column address width.
- PIX_W, 24, pixel width (R 23:16, G 15:8, B 7:0).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; connected to the processing stage's filter_done.
- rd_row  out  ADDR_W  output-image read row.
- rd_col  out  ADDR_W  output-image read column.
- rd_pix  in  PIX_W  pixel at [rd_row, rd_col]; valid the cycle after the address is driven.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  consumer accepts the beat.
- m_data  out  PIX_W  pixel data.
- m_sof  out  1  beat is pixel (0,0).
- m_eol  out  1  beat is the last column of a row.
- m_eof  out  1  beat is pixel (IMG_H-1, IMG_W-1).
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_row=0, rd_col=0, m_valid=0, m_data=0, m_sof/m_eol/m_eof=0, busy=0, done=0; FIFO emptied; in-flight read discarded.
- Reset mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: start=1 -> RUN; address counter cleared to (0,0).
  - RUN: a read is issued in any cycle where (fifo_count + inflight) < FIFO_DEPTH. On issue, the address advances raster order (col+1; at col=IMG_W-1, col=0 and row+1). When the issued address is (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: no new reads. When the FIFO is empty and no read is in flight -> DONE.
  - DONE: done=1 for exactly one cycle; busy=0 from this cycle -> IDLE.
- busy=1 in RUN and DRAIN only.
- inflight is a 1-bit register, set on the cycle a read is issued. Next cycle, rd_pix plus markers computed from the issued address are pushed into the FIFO.
- FIFO entry = {sof, eol, eof, pix}, PIX_W+3 bits.
- Stream outputs reflect the FIFO head; m_valid = !empty. Pop on m_valid & m_ready.
- Push and pop in the same cycle are allowed at any fill level, including full, because the credit check guarantees no overflow.
- Latency: start sampled at edge k. Read of (0,0) issued in cycle k+1, data arrives k+2, m_valid=1 from cycle k+3.
- Throughput: 1 beat/cycle with m_ready held high; total IMG_W*IMG_H beats.
- m_data and markers hold stable while m_valid=1 and m_ready=0.
- start while busy or in DONE is ignored.
- start in the same cycle as reset deassertion is ignored.
- rd_row/rd_col hold their last value outside RUN. In DRAIN they remain at the final address (no wrap to 0).
- Marker widths: eol when col==IMG_W-1; sof when row==0 && col==0; eof when both are maximal. All compares are at ADDR_W width.

Decomposition:
- Shared package img_pkg: IMG_W, IMG_H, ADDR_W, PIX_W constants; a pixel typedef; a stream-beat typedef {sof, eol, eof, pix}.
- Sub-module stream_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, count. Pointers have one extra wrap bit.
- The top level holds the FSM, address counter and credit logic.

Test Plan:
- Frame with m_ready=1, rd_pix={row,col,8'hA5} model -> m_valid rises at k+3. Exactly 4096 beats, in raster order with matching data. m_sof on beat 0 only; m_eol on beats 63,127,...,4095; m_eof on beat 4095 only. done pulses once, the cycle after the last accept.
- m_ready=0 for 100 cycles after start -> exactly 4 reads issued (addresses (0,0)..(0,3)), then rd_col frozen at 3 then advancing only as beats pop. m_data holds (0,0) throughout. No loss once m_ready=1.
- Random m_ready (50%, fixed seed) over 3 frames -> scoreboard matches 12288 beats. Never more than FIFO_DEPTH outstanding. done count = 3.
- start pulsed again at beat 1000 and during DONE -> ignored: one frame of 4096 beats, one done pulse.
- rst_n low at beat 2000 for 2 cycles -> m_valid, busy and rd_row/rd_col are 0 immediately (asynchronous). No done pulse. A new start produces a full clean frame beginning with m_sof at (0,0).
- FIFO full with push and pop in the same cycle (m_ready toggles each cycle at steady state) -> count stays bounded, no overflow or underflow assertion fires.

Source files
------------

// File: rtl/img_pkg.sv
// Shared constants and types for the image output streaming path.
package img_pkg;

    localparam int IMG_W      = 64;
    localparam int IMG_H      = 64;
    localparam int ADDR_W     = 6;
    localparam int PIX_W      = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);

    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        logic   sof;
        logic   eol;
        logic   eof;
        pixel_t pix;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Tag a pixel with frame/line markers derived from its raster position.
    function automatic beat_t make_beat(input logic [ADDR_W-1:0] row,
                                        input logic [ADDR_W-1:0] col,
                                        input pixel_t            pix);
        beat_t b;
        b.sof = (row == '0) && (col == '0);
        b.eol = (col == COL_LAST);
        b.eof = (row == ROW_LAST) && (col == COL_LAST);
        b.pix = pix;
        return b;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module stream_fifo
    import img_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;

    // Storage and pointers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q[PTR_W-1:0]] <= din;
                wptr_q                   <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign dout  = mem_q[rptr_q[PTR_W-1:0]];
    assign count = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                   (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

endmodule

// File: rtl/frame_streamer.sv
// Reads the finished output image in raster order and presents it as a
// valid/ready pixel stream with sof/eol/eof markers.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; read address parked
//   ST_RUN   | issuing reads whenever FIFO credit allows
//   ST_DRAIN | last address issued; waiting for FIFO and read pipe to empty
//   ST_DONE  | one-cycle done pulse, then back to idle
//
// rd_row/rd_col show the address being read while a read is issued and
// otherwise hold the last issued address, so a stalled stream leaves the
// bus parked on the newest pixel requested.
module frame_streamer
    import img_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_row,
    output logic [ADDR_W-1:0] rd_col,
    input  logic [PIX_W-1:0]  rd_pix,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              done
);
    state_t            state_q, state_d;
    logic              armed_q;
    logic [ADDR_W-1:0] nxt_row_q, nxt_row_d, nxt_col_q, nxt_col_d;
    logic [ADDR_W-1:0] last_row_q, last_row_d, last_col_q, last_col_d;
    logic              inflight_q;
    logic              start_ok, issue, last_issue;
    logic              push, pop, fifo_empty, fifo_full;
    logic [CNT_W-1:0]  fifo_count, credit_used;
    beat_t             beat_in, beat_out;

    // armed_q masks a start that coincides with the first edge after reset.
    assign start_ok    = start && armed_q;
    assign credit_used = fifo_count + CNT_W'(inflight_q);
    assign issue       = (state_q == ST_RUN) && !fifo_full &&
                         (credit_used < CNT_W'(FIFO_DEPTH));
    assign last_issue  = issue && (nxt_row_q == ROW_LAST) && (nxt_col_q == COL_LAST);
    assign push        = inflight_q;
    assign pop         = !fifo_empty && m_ready;
    assign beat_in     = make_beat(last_row_q, last_col_q, rd_pix);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address counters, read pipe flag and post-reset start mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            nxt_row_q  <= '0;
            nxt_col_q  <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            armed_q    <= 1'b1;
            nxt_row_q  <= nxt_row_d;
            nxt_col_q  <= nxt_col_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            inflight_q <= issue;
        end
    end

    // Next-state decode; DRAIN exits as the final beat is accepted
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_RUN;
            ST_RUN:   if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if (!inflight_q && (fifo_count == CNT_W'(pop))) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Raster address advance; the final address is held rather than wrapped
    always_comb begin
        nxt_row_d  = nxt_row_q;
        nxt_col_d  = nxt_col_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        if ((state_q == ST_IDLE) && start_ok) begin
            nxt_row_d  = '0;
            nxt_col_d  = '0;
            last_row_d = '0;
            last_col_d = '0;
        end else if (issue) begin
            last_row_d = nxt_row_q;
            last_col_d = nxt_col_q;
            if (!last_issue) begin
                if (nxt_col_q == COL_LAST) begin
                    nxt_col_d = '0;
                    nxt_row_d = nxt_row_q + 1'b1;
                end else begin
                    nxt_col_d = nxt_col_q + 1'b1;
                end
            end
        end
    end

    // Outputs
    always_comb begin
        busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        done    = (state_q == ST_DONE);
        rd_row  = issue ? nxt_row_q : last_row_q;
        rd_col  = issue ? nxt_col_q : last_col_q;
        m_valid = !fifo_empty;
        m_data  = beat_out.pix;
        m_sof   = beat_out.sof;
        m_eol   = beat_out.eol;
        m_eof   = beat_out.eof;
    end

    stream_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (beat_in),
        .dout  (beat_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;
    import img_pkg::*;

    localparam int NPIX = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic [ADDR_W-1:0] rd_row, rd_col;
    logic [PIX_W-1:0]  rd_pix;
    logic              m_valid, m_sof, m_eol, m_eof, busy, done;
    logic [PIX_W-1:0]  m_data;

    int checks = 0;
    int errors = 0;

    frame_streamer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rd_row  (rd_row),
        .rd_col  (rd_col),
        .rd_pix  (rd_pix),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Image memory model: one-cycle read latency
    always @(posedge clk) rd_pix <= {2'b00, rd_row, 2'b00, rd_col, 8'hA5};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready pattern: 0 low, 1 high, 2 random, 3 toggle
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            2:       m_ready = 1'($urandom_range(1, 0));
            default: m_ready = ~m_ready;
        endcase
    end

    // Observation: accepted beats, done pulses, reads and protocol counters
    logic [BEAT_W-1:0] obs_q[$];
    logic [BEAT_W-1:0] exp_q[$];
    int acc_cyc_last = 0, done_cnt = 0, done_cyc = 0, reads_cnt = 0;
    int bound_viol = 0, stable_viol = 0, ovf_cnt = 0, udf_cnt = 0;
    logic              hold_pend = 1'b0;
    logic [BEAT_W-1:0] hold_val = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                obs_q.push_back({m_sof, m_eol, m_eof, m_data});
                acc_cyc_last = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (dut.inflight_q) reads_cnt = reads_cnt + 1;
            if (int'(dut.fifo_count) + int'(dut.inflight_q) > FIFO_DEPTH) bound_viol = bound_viol + 1;
            if (dut.push && !dut.pop && dut.fifo_full) ovf_cnt = ovf_cnt + 1;
            if (dut.pop && dut.fifo_empty) udf_cnt = udf_cnt + 1;
            if (hold_pend && (!m_valid || ({m_sof, m_eol, m_eof, m_data} != hold_val)))
                stable_viol = stable_viol + 1;
            hold_pend = m_valid && !m_ready;
            hold_val  = {m_sof, m_eol, m_eof, m_data};
        end else begin
            hold_pend = 1'b0;
        end
    end

    int start_cyc = 0;

    // Pulse start for one edge and queue the full frame the consumer should see
    task automatic pulse_start();
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                exp_q.push_back({1'(r == 0 && c == 0), 1'(c == IMG_W - 1),
                                 1'(r == IMG_H - 1 && c == IMG_W - 1),
                                 2'b00, ADDR_W'(r), 2'b00, ADDR_W'(c), 8'hA5});
            end
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int d0, input int budget, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            ok = (done_cnt != d0);
            n++;
        end
    endtask

    task automatic wait_beats(input int target, input int budget, output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk); #1;
            ok = (obs_q.size() >= target);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_valid, busy, done, m_sof, m_eol, m_eof} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000", {m_valid, busy, done, m_sof, m_eol, m_eof});
        end
        checks++;
        if (rd_row !== '0 || rd_col !== '0 || m_data !== '0) begin
            errors++;
            $display("FAIL reset_addr_data: got row %0d col %0d data %h required 0 0 0", rd_row, rd_col, m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_at_reset_release: busy %b m_valid %b required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_frame_basic();
        int base = obs_q.size();
        int d0 = done_cnt;
        int idx;
        logic [2:0] vseq;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 1;
        pulse_start();
        @(negedge clk); #1 vseq[2] = m_valid;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b required 1", busy);
        end
        @(negedge clk); #1 vseq[1] = m_valid;
        @(negedge clk); #1 vseq[0] = m_valid;
        checks++;
        if (vseq !== 3'b001) begin
            errors++;
            $display("FAIL basic_latency: m_valid k+1..k+3 got %b required 001", vseq);
        end
        checks++;
        if (m_sof !== 1'b1 || m_data !== 24'h0000A5) begin
            errors++;
            $display("FAIL basic_first_beat: sof %b data %h required 1 0000a5", m_sof, m_data);
        end
        wait_done(d0, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_done_timeout: done_cnt %0d required %0d", done_cnt, d0 + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_at_done: got %b required 0", busy);
        end
        checks++;
        if (done_cyc != acc_cyc_last + 1) begin
            errors++;
            $display("FAIL basic_done_timing: done cycle %0d required %0d", done_cyc, acc_cyc_last + 1);
        end
        checks++;
        if (acc_cyc_last != start_cyc + 2 + NPIX - 1) begin
            errors++;
            $display("FAIL basic_throughput: last accept cycle %0d required %0d", acc_cyc_last, start_cyc + 2 + NPIX - 1);
        end
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d required %0d", done_cnt - d0, 1);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL basic_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL basic_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL basic_beat_count: got %0d required %0d", obs_q.size() - base, NPIX);
        end
    endtask

    task automatic test_backpressure();
        int base = obs_q.size();
        int d0 = done_cnt;
        int r0 = reads_cnt;
        int s0 = stable_viol;
        int idx;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 0;
        pulse_start();
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if (reads_cnt - r0 != FIFO_DEPTH) begin
            errors++;
            $display("FAIL bp_reads: got %0d reads required %0d", reads_cnt - r0, FIFO_DEPTH);
        end
        checks++;
        if (rd_row !== 6'd0 || rd_col !== 6'd3) begin
            errors++;
            $display("FAIL bp_addr_frozen: got (%0d,%0d) required (0,3)", rd_row, rd_col);
        end
        checks++;
        if (m_valid !== 1'b1 || m_sof !== 1'b1 || m_data !== 24'h0000A5) begin
            errors++;
            $display("FAIL bp_head: valid %b sof %b data %h required 1 1 0000a5", m_valid, m_sof, m_data);
        end
        ready_mode = 1;
        wait_done(d0, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_done_timeout: done_cnt %0d required %0d", done_cnt, d0 + 1);
        end
        checks++;
        if (stable_viol != s0) begin
            errors++;
            $display("FAIL bp_hold_stable: got %0d violations required 0", stable_viol - s0);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL bp_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL bp_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL bp_beat_count: got %0d required %0d", obs_q.size() - base, NPIX);
        end
    endtask

    task automatic test_random_frames();
        int base = obs_q.size();
        int d0 = done_cnt;
        int b0 = bound_viol;
        int s0 = stable_viol;
        int idx;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 2;
        for (int f = 0; f < 3; f++) begin
            pulse_start();
            wait_done(d0 + f, 20000, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_done_timeout: frame %0d done_cnt %0d required %0d", f, done_cnt - d0, f + 1);
            end
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (done_cnt - d0 != 3) begin
            errors++;
            $display("FAIL rand_done_count: got %0d required 3", done_cnt - d0);
        end
        checks++;
        if (bound_viol != b0 || stable_viol != s0) begin
            errors++;
            $display("FAIL rand_protocol: outstanding violations %0d hold violations %0d required 0 0", bound_viol - b0, stable_viol - s0);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL rand_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL rand_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL rand_beat_count: got %0d required %0d", obs_q.size() - base, 3 * NPIX);
        end
    endtask

    task automatic test_start_ignored();
        int base = obs_q.size();
        int d0 = done_cnt;
        int idx;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 1;
        pulse_start();
        wait_beats(base + 1000, 5000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ign_beats_timeout: got %0d beats required 1000", obs_q.size() - base);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(d0, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ign_done_timeout: done_cnt %0d required %0d", done_cnt, d0 + 1);
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ign_single_frame: busy %b done pulses %0d required 0 1", busy, done_cnt - d0);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL ign_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL ign_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL ign_beat_count: got %0d required %0d", obs_q.size() - base, NPIX);
        end
    endtask

    task automatic test_reset_midframe();
        int base = obs_q.size();
        int d0 = done_cnt;
        int idx;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 1;
        pulse_start();
        wait_beats(base + 2000, 5000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_beats_timeout: got %0d beats required 2000", obs_q.size() - base);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || rd_row !== '0 || rd_col !== '0) begin
            errors++;
            $display("FAIL rstmid_async: valid %b busy %b row %0d col %0d required 0 0 0 0", m_valid, busy, rd_row, rd_col);
        end
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d pulses required 0", done_cnt - d0);
        end
        base = obs_q.size();
        pulse_start();
        wait_done(d0, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_done_timeout: done_cnt %0d required %0d", done_cnt, d0 + 1);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL rstmid_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL rstmid_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL rstmid_beat_count: got %0d required %0d", obs_q.size() - base, NPIX);
        end
    endtask

    task automatic test_toggle_full();
        int base = obs_q.size();
        int d0 = done_cnt;
        int o0 = ovf_cnt;
        int u0 = udf_cnt;
        int b0 = bound_viol;
        int idx;
        logic ok;
        logic [BEAT_W-1:0] exp;
        ready_mode = 3;
        pulse_start();
        wait_done(d0, 20000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL toggle_done_timeout: done_cnt %0d required %0d", done_cnt, d0 + 1);
        end
        checks++;
        if (ovf_cnt != o0 || udf_cnt != u0 || bound_viol != b0) begin
            errors++;
            $display("FAIL toggle_fifo_bounds: overflow %0d underflow %0d credit %0d required 0 0 0", ovf_cnt - o0, udf_cnt - u0, bound_viol - b0);
        end
        idx = base;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            checks++;
            if (idx >= obs_q.size()) begin
                errors++;
                $display("FAIL toggle_beat %0d: missing, required %h", idx - base, exp);
            end else if (obs_q[idx] !== exp) begin
                errors++;
                $display("FAIL toggle_beat %0d: got %h required %h", idx - base, obs_q[idx], exp);
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != idx) begin
            errors++;
            $display("FAIL toggle_beat_count: got %0d required %0d", obs_q.size() - base, NPIX);
        end
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_backpressure();
        test_random_frames();
        test_start_ignored();
        test_reset_midframe();
        test_toggle_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
